// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the IF (instruction read) and MEM (data) pipeline stages.
// Optional stall counters i_stall_cnt/d_stall_cnt are built when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter #(
    parameter int WORD_SIZE   = 16,
    parameter int MAX_D_BURST = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic                 i_ack,
    output logic [WORD_SIZE-1:0] i_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 d_ack,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic                 mem_ack,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 err
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [15:0]          i_stall_cnt,
    output logic [15:0]          d_stall_cnt
`endif
);

    localparam int BW = $clog2(MAX_D_BURST + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_D_BURST);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} stateT;

    stateT                state, stateNext;
    logic [BW-1:0]        burstCnt, burstCntNext;
    logic [TW-1:0]        timer, timerNext;
    logic                 iFlush, iFlushNext;
    logic                 memReqNext, memWeNext;
    logic [WORD_SIZE-1:0] memAddrNext, memWdataNext;
    logic                 iAckNext, dAckNext, errNext;
    logic [WORD_SIZE-1:0] iRdataNext, dRdataNext;
    logic                 forceIf;

    // IF wins only once MEM has used up its burst allowance while IF waits.
    assign forceIf = i_req && (burstCnt == BURST_MAX);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        stateNext    = state;
        burstCntNext = burstCnt;
        timerNext    = timer;
        iFlushNext   = iFlush;
        memReqNext   = mem_req;
        memWeNext    = mem_we;
        memAddrNext  = mem_addr;
        memWdataNext = mem_wdata;
        iRdataNext   = i_rdata;
        dRdataNext   = d_rdata;
        iAckNext     = 1'b0;
        dAckNext     = 1'b0;
        errNext      = 1'b0;

        case (state)
            IDLE: begin
                timerNext  = '0;
                iFlushNext = 1'b0;
                if (!i_req)
                    burstCntNext = '0;
                if (d_req && !forceIf) begin
                    stateNext    = BUSY_D;
                    memReqNext   = 1'b1;
                    memWeNext    = d_we;
                    memAddrNext  = d_addr;
                    memWdataNext = d_wdata;
                    if (i_req && burstCnt != BURST_MAX)
                        burstCntNext = burstCnt + 1'b1;
                end else if (i_req) begin
                    stateNext    = BUSY_I;
                    memReqNext   = 1'b1;
                    memWeNext    = 1'b0;
                    memAddrNext  = i_addr;
                    burstCntNext = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                timerNext = timer + 1'b1;
                if (state == BUSY_I && !i_req)
                    iFlushNext = 1'b1;
                if (mem_ack) begin
                    stateNext  = IDLE;
                    timerNext  = '0;
                    memReqNext = 1'b0;
                    memWeNext  = 1'b0;
                    // A flushed fetch still completes on the bus but is not reported.
                    if (state == BUSY_I) begin
                        if (i_req && !iFlush) begin
                            iAckNext   = 1'b1;
                            iRdataNext = mem_rdata;
                        end
                    end else begin
                        dAckNext = 1'b1;
                        if (!mem_we)
                            dRdataNext = mem_rdata;
                    end
                end else if (timer == TIMER_LAST) begin
                    stateNext  = IDLE;
                    timerNext  = '0;
                    memReqNext = 1'b0;
                    memWeNext  = 1'b0;
                    errNext    = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            burstCnt  <= '0;
            timer     <= '0;
            iFlush    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            err       <= 1'b0;
        end else begin
            state     <= stateNext;
            burstCnt  <= burstCntNext;
            timer     <= timerNext;
            iFlush    <= iFlushNext;
            mem_req   <= memReqNext;
            mem_we    <= memWeNext;
            mem_addr  <= memAddrNext;
            mem_wdata <= memWdataNext;
            i_ack     <= iAckNext;
            d_ack     <= dAckNext;
            i_rdata   <= iRdataNext;
            d_rdata   <= dRdataNext;
            err       <= errNext;
        end
    end

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            i_stall_cnt <= '0;
            d_stall_cnt <= '0;
        end else begin
            if (i_req && !i_ack && i_stall_cnt != 16'hFFFF)
                i_stall_cnt <= i_stall_cnt + 1'b1;
            if (d_req && !d_ack && d_stall_cnt != 16'hFFFF)
                d_stall_cnt <= d_stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter: reset, IF read, priority, burst limit, flush, timeout, reset abort.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we, mem_ack;
    logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic        i_ack, d_ack, mem_req, mem_we, err;
    logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.WORD_SIZE(16), .MAX_D_BURST(4), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
    );

    always #5 clk = ~clk;

    // Advance one cycle; outputs are observed 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_mem_req(input string name);
        bit seen = 0;
        for (int n = 0; n < 8 && !seen; n++) begin
            step();
            if (mem_req === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL %s_grant_timeout: mem_req=%b want 1", name, mem_req); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        checks++; if ({mem_req, mem_we, i_ack, d_ack, err} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 00000", {mem_req, mem_we, i_ack, d_ack, err}); end
        checks++; if ({mem_addr, mem_wdata, i_rdata, d_rdata} !== 64'h0) begin errors++; $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, i_rdata, d_rdata}); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_if_read();
        i_req = 1'b1; i_addr = 16'h0010;
        step();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL if_memreq: got %b want 1", mem_req); end
        checks++; if (mem_addr !== 16'h0010) begin errors++; $display("FAIL if_addr: got %h want 0010", mem_addr); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL if_we: got %b want 0", mem_we); end
        step();
        checks++; if ({mem_req, i_ack} !== 2'b10) begin errors++; $display("FAIL if_hold: got %b want 10", {mem_req, i_ack}); end
        mem_ack = 1'b1; mem_rdata = 16'hA55A;
        step();
        checks++; if (i_ack !== 1'b1) begin errors++; $display("FAIL if_ack: got %b want 1", i_ack); end
        checks++; if (i_rdata !== 16'hA55A) begin errors++; $display("FAIL if_rdata: got %h want a55a", i_rdata); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL if_memreq_drop: got %b want 0", mem_req); end
        mem_ack = 1'b0; i_req = 1'b0;
        step();
        checks++; if ({i_ack, mem_req} !== 2'b00) begin errors++; $display("FAIL if_ack_pulse: got %b want 00", {i_ack, mem_req}); end
    endtask

    task automatic test_priority();
        i_req = 1'b1; i_addr = 16'h0040;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234;
        step();
        checks++; if ({mem_req, mem_we} !== 2'b11) begin errors++; $display("FAIL prio_dwrite: got %b want 11", {mem_req, mem_we}); end
        checks++; if (mem_addr !== 16'h0200) begin errors++; $display("FAIL prio_daddr: got %h want 0200", mem_addr); end
        checks++; if (mem_wdata !== 16'h1234) begin errors++; $display("FAIL prio_wdata: got %h want 1234", mem_wdata); end
        step();
        mem_ack = 1'b1; mem_rdata = 16'h9999;
        step();
        checks++; if ({d_ack, i_ack, mem_req} !== 3'b100) begin errors++; $display("FAIL prio_dack: got %b want 100", {d_ack, i_ack, mem_req}); end
        mem_ack = 1'b0; d_req = 1'b0; d_we = 1'b0;
        step();
        checks++; if ({mem_req, mem_we, d_ack} !== 3'b100) begin errors++; $display("FAIL prio_igrant: got %b want 100", {mem_req, mem_we, d_ack}); end
        checks++; if (mem_addr !== 16'h0040) begin errors++; $display("FAIL prio_iaddr: got %h want 0040", mem_addr); end
        step();
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        step();
        checks++; if ({i_ack, d_ack} !== 2'b10) begin errors++; $display("FAIL prio_iack: got %b want 10", {i_ack, d_ack}); end
        checks++; if (i_rdata !== 16'hBEEF) begin errors++; $display("FAIL prio_irdata: got %h want beef", i_rdata); end
        checks++; if (d_rdata !== 16'h0000) begin errors++; $display("FAIL prio_write_no_rdata: got %h want 0000", d_rdata); end
        mem_ack = 1'b0; i_req = 1'b0;
        step();
    endtask

    task automatic test_burst_limit();
        logic [15:0] expAddr [6];
        expAddr = '{16'h0300, 16'h0300, 16'h0300, 16'h0300, 16'h0100, 16'h0300};
        i_req = 1'b1; i_addr = 16'h0100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0300;
        for (int k = 0; k < 6; k++) begin
            wait_mem_req("burst");
            checks++; if (mem_addr !== expAddr[k]) begin errors++; $display("FAIL burst_grant%0d: got %h want %h", k, mem_addr, expAddr[k]); end
            step();
            mem_ack = 1'b1; mem_rdata = 16'h7000 + 16'(k);
            step();
            if (k == 4) begin
                checks++; if ({i_ack, d_ack} !== 2'b10) begin errors++; $display("FAIL burst_ack%0d: got %b want 10", k, {i_ack, d_ack}); end
                checks++; if (i_rdata !== 16'h7004) begin errors++; $display("FAIL burst_irdata: got %h want 7004", i_rdata); end
            end else begin
                checks++; if ({i_ack, d_ack} !== 2'b01) begin errors++; $display("FAIL burst_ack%0d: got %b want 01", k, {i_ack, d_ack}); end
            end
            if (k == 5) begin
                checks++; if (d_rdata !== 16'h7005) begin errors++; $display("FAIL burst_drdata: got %h want 7005", d_rdata); end
                i_req = 1'b0; d_req = 1'b0;
            end
            mem_ack = 1'b0;
        end
        step();
        checks++; if (dut.burstCnt !== '0) begin errors++; $display("FAIL burst_cnt_clear: got %0d want 0", dut.burstCnt); end
    endtask

    task automatic test_flush();
        i_req = 1'b1; i_addr = 16'h0500;
        step();
        checks++; if (mem_addr !== 16'h0500) begin errors++; $display("FAIL flush_addr: got %h want 0500", mem_addr); end
        i_req = 1'b0;
        step();
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        step();
        checks++; if ({i_ack, mem_req} !== 2'b00) begin errors++; $display("FAIL flush_noack: got %b want 00", {i_ack, mem_req}); end
        checks++; if (i_rdata !== 16'h7004) begin errors++; $display("FAIL flush_rdata: got %h want 7004", i_rdata); end
        mem_ack = 1'b0;
        step();
        checks++; if ({i_ack, d_ack, mem_req} !== 3'b000) begin errors++; $display("FAIL flush_idle: got %b want 000", {i_ack, d_ack, mem_req}); end
    endtask

    task automatic test_timeout();
        int highCycles = 0;
        int errPulses = 0;
        int ackSeen = 0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0600; d_wdata = 16'h5555;
        step();
        while (mem_req === 1'b1 && highCycles < 200) begin
            highCycles++;
            if (err === 1'b1) errPulses++;
            if (i_ack === 1'b1 || d_ack === 1'b1) ackSeen++;
            step();
        end
        checks++; if (highCycles != 64) begin errors++; $display("FAIL timeout_len: got %0d want 64", highCycles); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b want 1", err); end
        if (err === 1'b1) errPulses++;
        if (i_ack === 1'b1 || d_ack === 1'b1) ackSeen++;
        step();
        checks++; if ({mem_req, mem_we, err} !== 3'b110) begin errors++; $display("FAIL timeout_regrant: got %b want 110", {mem_req, mem_we, err}); end
        step();
        mem_ack = 1'b1;
        step();
        checks++; if (d_ack !== 1'b1) begin errors++; $display("FAIL timeout_retry_ack: got %b want 1", d_ack); end
        if (err === 1'b1) errPulses++;
        checks++; if (errPulses != 1) begin errors++; $display("FAIL timeout_err_once: got %0d want 1", errPulses); end
        checks++; if (ackSeen != 0) begin errors++; $display("FAIL timeout_noack: got %0d want 0", ackSeen); end
        mem_ack = 1'b0; d_req = 1'b0; d_we = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_access();
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0700;
        step();
        checks++; if ({mem_req, mem_addr} !== {1'b1, 16'h0700}) begin errors++; $display("FAIL rst_mid_grant: got %h want 10700", {mem_req, mem_addr}); end
        step();
        mem_ack = 1'b1; mem_rdata = 16'h1111; reset = 1'b1;
        step();
        checks++; if ({mem_req, mem_we, i_ack, d_ack, err} !== 5'b0) begin errors++; $display("FAIL rst_mid_ctrl: got %b want 00000", {mem_req, mem_we, i_ack, d_ack, err}); end
        checks++; if ({mem_addr, mem_wdata, i_rdata, d_rdata} !== 64'h0) begin errors++; $display("FAIL rst_mid_data: got %h want 0", {mem_addr, mem_wdata, i_rdata, d_rdata}); end
        reset = 1'b0; d_req = 1'b0;
        step();
        checks++; if ({mem_req, d_ack, d_rdata} !== 18'h0) begin errors++; $display("FAIL rst_stray_ack: got %h want 0", {mem_req, d_ack, d_rdata}); end
        mem_ack = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        test_reset();
        test_if_read();
        test_priority();
        test_burst_limit();
        test_flush();
        test_timeout();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
